// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment figure-8 animation sequencer.
// Contents: frame index type, frame count, FSM state encoding, first-frame
// indices for forward and reverse playback.
package seven_segment_pkg;

    typedef logic [2:0] frame_t;

    localparam int unsigned FRAME_COUNT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } anim_state_t;

    localparam frame_t FRAME_FIRST_FWD = 3'd0;
    localparam frame_t FRAME_FIRST_REV = 3'd7;

endpackage

// File: rtl/frame_tick_prescaler.sv
// Frame-period prescaler: counts 0..period-1 and emits a one-cycle tick on
// the last count. The period is latched on clear and re-latched on each tick,
// so a new period only takes effect at a frame boundary.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - force count to 0 and latch period_eff (no tick)
//   hold        - freeze the count (no tick)
//   period_eff  - cycles per frame, already forced to >= 1 by the caller
//   tick        - high on the cycle whose edge ends the current frame
module frame_tick_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      hold,
    input  logic [PRESCALE_WIDTH-1:0] period_eff,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count;
    logic [PRESCALE_WIDTH-1:0] period_q;
    logic                      at_last;

    assign at_last = (count == period_q - PRESCALE_WIDTH'(1));
    assign tick    = !clear && !hold && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            period_q <= PRESCALE_WIDTH'(1);
        end else if (clear) begin
            count    <= '0;
            period_q <= period_eff;
        end else if (!hold) begin
            if (at_last) begin
                count    <= '0;
                period_q <= period_eff;
            end else begin
                count <= count + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/seven_segment_animation_sequencer.sv
// Frame sequencer for the seven-segment figure-8 animation decoder.
// Steps a 3-bit frame index once per programmable period, forward or reverse,
// in continuous or single-shot mode, with start/stop/pause control.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - pulse: begin or restart playback
//   stop         - pulse: abort playback and blank (highest priority)
//   pause        - level: freeze the current frame
//   direction    - 0 forward (0->7), 1 reverse (7->0); sampled at ticks
//   single_shot  - 1 stop after one loop; sampled at the loop-ending tick
//   period       - cycles per frame, 0 treated as 1
//   frame        - current frame index (registered)
//   frame_valid  - a frame is being displayed (registered)
//   loop_done    - one-cycle pulse after 8 frames (registered)
//   busy         - state is RUN or PAUSE (registered)
module seven_segment_animation_sequencer
    import seven_segment_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      direction,
    input  logic                      single_shot,
    input  logic [PRESCALE_WIDTH-1:0] period,
    output frame_t                    frame,
    output logic                      frame_valid,
    output logic                      loop_done,
    output logic                      busy
);

    anim_state_t               state, state_n;
    frame_t                    frame_n;
    frame_t                    shown, shown_n;
    logic                      loop_done_n;
    logic                      tick;
    logic                      presc_clear;
    logic [PRESCALE_WIDTH-1:0] period_eff;

    assign period_eff  = (period == '0) ? PRESCALE_WIDTH'(1) : period;
    // Prescaler sits at 0 while idle and restarts on any start/stop.
    assign presc_clear = (state == IDLE) || start || stop;

    frame_tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (presc_clear),
        .hold      (pause),
        .period_eff(period_eff),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame       <= FRAME_FIRST_FWD;
            shown       <= '0;
            loop_done   <= 1'b0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            frame       <= frame_n;
            shown       <= shown_n;
            loop_done   <= loop_done_n;
            frame_valid <= (state_n != IDLE);
            busy        <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        frame_n     = frame;
        shown_n     = shown;
        loop_done_n = 1'b0;
        if (stop) begin
            state_n = IDLE;
            frame_n = FRAME_FIRST_FWD;
            shown_n = '0;
        end else if (start) begin
            // A restart while active honours pause on the same edge.
            state_n = (state != IDLE && pause) ? PAUSE : RUN;
            frame_n = direction ? FRAME_FIRST_REV : FRAME_FIRST_FWD;
            shown_n = '0;
        end else begin
            case (state)
                RUN, PAUSE: begin
                    if (pause) begin
                        state_n = PAUSE;
                    end else begin
                        state_n = RUN;
                        if (tick) begin
                            frame_n = direction ? frame - 3'd1 : frame + 3'd1;
                            shown_n = shown + 3'd1;
                            if (shown == frame_t'(FRAME_COUNT - 1)) begin
                                loop_done_n = 1'b1;
                                if (single_shot) begin
                                    state_n = IDLE;
                                    frame_n = FRAME_FIRST_FWD;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_animation_sequencer.sv
module tb_seven_segment_animation_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, pause, direction, single_shot;
    logic [23:0] period;
    logic [2:0]  frame;
    logic        frame_valid, loop_done, busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    seven_segment_animation_sequencer #(
        .PRESCALE_WIDTH(24)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .direction  (direction),
        .single_shot(single_shot),
        .period     (period),
        .frame      (frame),
        .frame_valid(frame_valid),
        .loop_done  (loop_done),
        .busy       (busy)
    );

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observed outputs packed as {frame_valid, busy, loop_done, frame}.
    function automatic logic [5:0] obs();
        return {frame_valid, busy, loop_done, frame};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; start = 0; stop = 0; pause = 0;
        direction = 0; single_shot = 0; period = 24'd1;
        cycles(3);
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL reset_hold: got %b want %b", obs(), 6'b00_0_000); end
        #3 rst_n = 1'b1;
        cycles(4);
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL reset_idle: got %b want %b", obs(), 6'b00_0_000); end
    endtask

    task automatic test_forward_continuous;
        period = 24'd4; direction = 0; single_shot = 0;
        start = 1; cycles(1); start = 0;                 // edge 0
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL fwd_e0: got %b want %b", obs(), 6'b11_0_000); end
        cycles(3);                                       // edge 3
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL fwd_e3: got %b want %b", obs(), 6'b11_0_000); end
        cycles(1);                                       // edge 4
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL fwd_e4: got %b want %b", obs(), 6'b11_0_001); end
        cycles(24);                                      // edge 28
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL fwd_e28: got %b want %b", obs(), 6'b11_0_111); end
        cycles(3);                                       // edge 31
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL fwd_e31: got %b want %b", obs(), 6'b11_0_111); end
        cycles(1);                                       // edge 32
        n_cmp++; if (obs() !== 6'b11_1_000) begin n_bad++; $display("FAIL fwd_e32_loop: got %b want %b", obs(), 6'b11_1_000); end
        cycles(1);                                       // edge 33
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL fwd_e33_pulse: got %b want %b", obs(), 6'b11_0_000); end
        cycles(31);                                      // edge 64
        n_cmp++; if (obs() !== 6'b11_1_000) begin n_bad++; $display("FAIL fwd_e64_loop2: got %b want %b", obs(), 6'b11_1_000); end
        stop = 1; cycles(1); stop = 0;
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL fwd_stop: got %b want %b", obs(), 6'b00_0_000); end
    endtask

    task automatic test_reverse_single_shot;
        period = 24'd2; direction = 1; single_shot = 1;
        start = 1; cycles(1); start = 0;                 // edge 0
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL rev_e0: got %b want %b", obs(), 6'b11_0_111); end
        cycles(2);                                       // edge 2
        n_cmp++; if (obs() !== 6'b11_0_110) begin n_bad++; $display("FAIL rev_e2: got %b want %b", obs(), 6'b11_0_110); end
        cycles(12);                                      // edge 14
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL rev_e14: got %b want %b", obs(), 6'b11_0_000); end
        cycles(2);                                       // edge 16
        n_cmp++; if (obs() !== 6'b00_1_000) begin n_bad++; $display("FAIL rev_e16_done: got %b want %b", obs(), 6'b00_1_000); end
        cycles(5);                                       // edge 21
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL rev_idle_after: got %b want %b", obs(), 6'b00_0_000); end
        single_shot = 0;
    endtask

    task automatic test_pause;
        period = 24'd3; direction = 0;
        start = 1; cycles(1); start = 0;                 // edge 0
        cycles(3);                                       // edge 3
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL pause_e3: got %b want %b", obs(), 6'b11_0_001); end
        pause = 1; cycles(1);                            // edge 4
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL pause_e4: got %b want %b", obs(), 6'b11_0_001); end
        cycles(5);                                       // edge 9
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL pause_e9: got %b want %b", obs(), 6'b11_0_001); end
        pause = 0; cycles(2);                            // edge 11
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL pause_e11: got %b want %b", obs(), 6'b11_0_001); end
        cycles(1);                                       // edge 12
        n_cmp++; if (obs() !== 6'b11_0_010) begin n_bad++; $display("FAIL pause_e12: got %b want %b", obs(), 6'b11_0_010); end
        // Restart with pause held: reloaded frame stays frozen.
        direction = 1; start = 1; pause = 1; cycles(1); start = 0;
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL pause_restart: got %b want %b", obs(), 6'b11_0_111); end
        cycles(3);
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL pause_restart_frozen: got %b want %b", obs(), 6'b11_0_111); end
        pause = 0; cycles(2);
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL pause_resume_pre: got %b want %b", obs(), 6'b11_0_111); end
        cycles(1);
        n_cmp++; if (obs() !== 6'b11_0_110) begin n_bad++; $display("FAIL pause_resume_tick: got %b want %b", obs(), 6'b11_0_110); end
        stop = 1; cycles(1); stop = 0; direction = 0;
    endtask

    task automatic test_zero_period_restart;
        period = 24'd0; direction = 0;
        start = 1; cycles(1); start = 0;                 // edge 0
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL zp_e0: got %b want %b", obs(), 6'b11_0_000); end
        cycles(1);                                       // edge 1
        n_cmp++; if (obs() !== 6'b11_0_001) begin n_bad++; $display("FAIL zp_e1: got %b want %b", obs(), 6'b11_0_001); end
        cycles(3);                                       // edge 4
        n_cmp++; if (obs() !== 6'b11_0_100) begin n_bad++; $display("FAIL zp_e4: got %b want %b", obs(), 6'b11_0_100); end
        start = 1; cycles(1); start = 0;                 // edge 5
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL zp_restart_e5: got %b want %b", obs(), 6'b11_0_000); end
        cycles(3);                                       // edge 8
        n_cmp++; if (obs() !== 6'b11_0_011) begin n_bad++; $display("FAIL zp_e8_noloop: got %b want %b", obs(), 6'b11_0_011); end
        cycles(4);                                       // edge 12
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL zp_e12: got %b want %b", obs(), 6'b11_0_111); end
        cycles(1);                                       // edge 13
        n_cmp++; if (obs() !== 6'b11_1_000) begin n_bad++; $display("FAIL zp_e13_loop: got %b want %b", obs(), 6'b11_1_000); end
        stop = 1; cycles(1); stop = 0;
    endtask

    task automatic test_stop_priority;
        period = 24'd1; direction = 0;
        start = 1; cycles(1); start = 0;                 // edge 0
        cycles(5);                                       // edge 5
        n_cmp++; if (obs() !== 6'b11_0_101) begin n_bad++; $display("FAIL stop_e5: got %b want %b", obs(), 6'b11_0_101); end
        stop = 1; start = 1; cycles(1); stop = 0; start = 0;
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL stop_over_start: got %b want %b", obs(), 6'b00_0_000); end
        // Stop on the loop-completing edge suppresses loop_done.
        start = 1; cycles(1); start = 0;                 // edge 0
        cycles(7);                                       // edge 7
        n_cmp++; if (obs() !== 6'b11_0_111) begin n_bad++; $display("FAIL stop_e7: got %b want %b", obs(), 6'b11_0_111); end
        stop = 1; cycles(1); stop = 0;                   // edge 8
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL stop_on_loop: got %b want %b", obs(), 6'b00_0_000); end
    endtask

    task automatic test_async_reset;
        period = 24'd2; direction = 0;
        start = 1; cycles(1); start = 0;                 // edge 0
        cycles(6);                                       // edge 6
        n_cmp++; if (obs() !== 6'b11_0_011) begin n_bad++; $display("FAIL arst_e6: got %b want %b", obs(), 6'b11_0_011); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL arst_immediate: got %b want %b", obs(), 6'b00_0_000); end
        #2 rst_n = 1'b1;
        cycles(5);
        n_cmp++; if (obs() !== 6'b00_0_000) begin n_bad++; $display("FAIL arst_stays_idle: got %b want %b", obs(), 6'b00_0_000); end
        start = 1; cycles(1); start = 0;
        n_cmp++; if (obs() !== 6'b11_0_000) begin n_bad++; $display("FAIL arst_restart: got %b want %b", obs(), 6'b11_0_000); end
        stop = 1; cycles(1); stop = 0;
    endtask

    initial begin
        test_reset();
        test_forward_continuous();
        test_reverse_single_shot();
        test_pause();
        test_zero_period_restart();
        test_stop_priority();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
